// File: rtl/clock_gen.sv
// Programmable clock/strobe generator: divides clk by a run-time period into a
// registered clk_out, plus one-cycle rise/fall strobes and an output-cycle counter.
module clock_gen #(
  parameter int PERIOD = 10,
  parameter int PW     = 16,
  parameter int CW     = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          period_load,
  input  logic [PW-1:0] period_in,
  output logic          clk_out,
  output logic          rise,
  output logic          fall,
  output logic [CW-1:0] cycle_count,
  output logic [PW-1:0] period_cur
);

  localparam logic [PW-1:0] PERIOD_INIT = PW'(PERIOD);
  localparam logic [PW-1:0] PERIOD_MIN  = PW'(2);

  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] per_q, per_d;
  logic [PW-1:0] pend_val_q, pend_val_d;
  logic          pend_q, pend_d;
  logic          clk_out_q, clk_out_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cycle_count_q, cycle_count_d;

  logic [PW-1:0] low_len;
  logic [PW-1:0] last_cnt;
  logic          wrap;

  always_comb begin
    low_len       = per_q - (per_q >> 1);
    last_cnt      = per_q - PW'(1);
    wrap          = (cnt_q == last_cnt);

    cnt_d         = cnt_q;
    per_d         = per_q;
    pend_d        = pend_q;
    pend_val_d    = pend_val_q;
    clk_out_d     = clk_out_q;
    rise_d        = 1'b0;
    fall_d        = 1'b0;
    cycle_count_d = cycle_count_q;

    if (enable) begin
      // A pending period is only adopted at the wrap, so every phase is full length.
      if (wrap) begin
        cnt_d = '0;
        if (pend_q) begin
          per_d  = pend_val_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
      clk_out_d = (cnt_d >= low_len);
      rise_d    = (cnt_d == low_len);
      fall_d    = wrap;
      if (rise_d) begin
        cycle_count_d = cycle_count_q + CW'(1);
      end
    end

    // Applied after the wrap logic so a load on the wrap edge waits for the next wrap.
    if (period_load) begin
      pend_d     = 1'b1;
      pend_val_d = (period_in < PERIOD_MIN) ? PERIOD_MIN : period_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      per_q         <= PERIOD_INIT;
      pend_q        <= 1'b0;
      pend_val_q    <= PERIOD_INIT;
      clk_out_q     <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      per_q         <= per_d;
      pend_q        <= pend_d;
      pend_val_q    <= pend_val_d;
      clk_out_q     <= clk_out_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign clk_out     = clk_out_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign cycle_count = cycle_count_q;
  assign period_cur  = per_q;

endmodule

// File: tb/tb_clock_gen.sv
// Scoreboard bench for clock_gen: a waveform-queue model predicts every output
// cycle; a monitor compares two instances (full and 4-bit counter) each cycle.
module tb_clock_gen;

  localparam int PERIOD = 10;
  localparam int PW     = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          period_load = 1'b0;
  logic [PW-1:0] period_in = '0;

  logic          clk_out, rise, fall;
  logic [31:0]   cycle_count;
  logic [PW-1:0] period_cur;
  logic          clk_out_s, rise_s, fall_s;
  logic [3:0]    cycle_count_s;
  logic [PW-1:0] period_cur_s;

  clock_gen #(.PERIOD(PERIOD), .PW(PW), .CW(32)) dut (
    .clk(clk), .reset(reset), .enable(enable), .period_load(period_load),
    .period_in(period_in), .clk_out(clk_out), .rise(rise), .fall(fall),
    .cycle_count(cycle_count), .period_cur(period_cur)
  );

  clock_gen #(.PERIOD(PERIOD), .PW(PW), .CW(4)) dut_small (
    .clk(clk), .reset(reset), .enable(enable), .period_load(period_load),
    .period_in(period_in), .clk_out(clk_out_s), .rise(rise_s), .fall(fall_s),
    .cycle_count(cycle_count_s), .period_cur(period_cur_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clk_out;
    logic        rise;
    logic        fall;
    logic [31:0] count;
    logic [15:0] per;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model: the remaining output levels of the current period are held
  // in a queue; when it runs dry a new period starts (low level, fall strobe).
  bit          m_wave[$];
  logic        m_level, m_rise, m_fall;
  logic [31:0] m_count;
  int          m_p, m_pend_val;
  bit          m_pend;

  function automatic void fill_period(int p);
    int low_n  = p - p / 2;
    int high_n = p / 2;
    m_wave.delete();
    for (int i = 0; i < low_n - 1; i++) m_wave.push_back(1'b0);
    for (int i = 0; i < high_n; i++) m_wave.push_back(1'b1);
  endfunction

  function automatic void model_step(bit rst, bit en, bit ld, int val);
    bit lvl;
    if (rst) begin
      m_p = PERIOD; m_pend = 0; m_pend_val = PERIOD;
      m_level = 0; m_rise = 0; m_fall = 0; m_count = 0;
      fill_period(m_p);
      return;
    end
    m_rise = 0;
    m_fall = 0;
    if (en) begin
      if (m_wave.size() == 0) begin
        if (m_pend) begin
          m_p = m_pend_val;
          m_pend = 0;
        end
        fill_period(m_p);
        m_fall  = m_level;
        m_level = 0;
      end else begin
        lvl = m_wave.pop_front();
        m_rise  = lvl && !m_level;
        m_level = lvl;
        if (m_rise) m_count = m_count + 1;
      end
    end
    if (ld) begin
      m_pend = 1;
      m_pend_val = (val < 2) ? 2 : val;
    end
  endfunction

  task automatic step(input bit rst, input bit en, input bit ld, input int val);
    exp_t e;
    @(negedge clk);
    reset = rst; enable = en; period_load = ld; period_in = PW'(val);
    model_step(rst, en, ld, val);
    e.clk_out = m_level; e.rise = m_rise; e.fall = m_fall;
    e.count = m_count; e.per = 16'(m_p);
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Monitor: every clk edge driven by the stimulus presents one output sample.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cyc++;
        check("clk_out", 32'(clk_out), 32'(e.clk_out));
        check("rise", 32'(rise), 32'(e.rise));
        check("fall", 32'(fall), 32'(e.fall));
        check("cycle_count", cycle_count, e.count);
        check("period_cur", 32'(period_cur), 32'(e.per));
        check("clk_out_cw4", 32'(clk_out_s), 32'(e.clk_out));
        check("rise_cw4", 32'(rise_s), 32'(e.rise));
        check("fall_cw4", 32'(fall_s), 32'(e.fall));
        check("cycle_count_cw4", 32'(cycle_count_s), 32'(e.count[3:0]));
        check("period_cur_cw4", 32'(period_cur_s), 32'(e.per));
        $display("cyc %0d rst=%0d en=%0d ld=%0d clk_out=%0d rise=%0d fall=%0d count=%0d per=%0d",
                 cyc, reset, enable, period_load, clk_out, rise, fall, cycle_count, period_cur);
      end
    end
  end

  initial begin
    int wait_cycles;
    // Free run at the reset period.
    step(1, 1, 0, 0);
    run(30);
    // Freeze mid-high phase for four cycles.
    step(1, 1, 0, 0);
    run(7);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    run(15);
    // Period change requested mid-period, adopted at the wrap.
    step(1, 1, 0, 0);
    run(2);
    step(0, 1, 1, 4);
    run(20);
    // Odd period, then clamped small periods.
    step(0, 1, 1, 7);
    run(25);
    step(0, 1, 1, 1);
    run(10);
    step(0, 1, 1, 0);
    run(6);
    // Reset with a pending load and enable/load also active.
    step(1, 1, 0, 0);
    step(0, 1, 1, 6);
    run(6);
    step(1, 1, 1, 3);
    run(15);
    // Load on the wrap edge itself.
    run(4);
    step(0, 1, 1, 3);
    run(12);
    // Fast period so the 4-bit counter wraps.
    step(0, 1, 1, 2);
    run(50);
    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 19) == 0,
           int'($urandom_range(0, 12)));
    end
    step(0, 1, 0, 0);
    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending samples, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_gen.md
Name: clock_gen

Overview:
- Synthesizable clock/strobe generator that replaces the behavioural clock source.
- Divides the reference clock `clk` by a programmable period to produce the processor pipeline clock `clk_out`.
- Also produces single-cycle edge strobes and a running count of output cycles for pipeline tracing.
- Sits at the top of the processor, driving every pipeline stage.

Parameters:
- PERIOD, 10: reset-time output period in `clk` cycles (≥2).
- PW, 16: width of the period register/input.
- CW, 32: width of the output cycle counter.

Ports:
- clk  in  1  reference clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = run, 0 = freeze the output clock in its current phase.
- period_load  in  1  one-cycle request to change the period.
- period_in  in  PW  new period value, sampled when period_load=1.
- clk_out  out  1  divided clock, registered.
- rise  out  1  one-cycle pulse in the first `clk` cycle where clk_out=1.
- fall  out  1  one-cycle pulse in the first `clk` cycle where clk_out=0 after a high phase.
- cycle_count  out  CW  number of clk_out rising edges since reset, wraps modulo 2^CW.
- period_cur  out  PW  period currently in effect.

Behaviour:
- Internal phase counter `cnt` (PW bits) and active period P.
  - Low length L = P − floor(P/2); high length H = floor(P/2).
  - For P=10: 5 low + 5 high. For P=7: 4 low + 3 high.
- Reset (reset=1 at a clk edge), next-cycle state:
  - cnt=0, P=PERIOD, clk_out=0, rise=0, fall=0, cycle_count=0, period_cur=PERIOD.
  - Any pending period load is cleared.
  - Reset dominates enable and period_load.
- Enabled cycle:
  - cnt ← (cnt==P−1) ? 0 : cnt+1.
  - clk_out ← (next cnt ≥ L).
  - rise ← (next cnt == L); fall ← (next cnt == 0 and cnt == P−1).
  - cycle_count increments on the same edge that sets rise.
  - First rise therefore appears L enabled cycles after reset deasserts (5 for PERIOD=10); first fall follows P enabled cycles after reset.
- Disabled cycle (enable=0):
  - cnt, clk_out and cycle_count hold.
  - rise=0, fall=0.
  - Period loads are still captured.
- Period change:
  - period_load=1 stores period_in in a pending register and sets a pending flag.
  - Values 0 or 1 are clamped to 2.
  - The pending period becomes P only at the wrap edge (cnt P−1→0), so no glitch or truncated phase ever appears on clk_out.
  - period_cur updates on that same edge.
  - A new load while one is pending overwrites it (last wins).
  - A load on the wrap edge itself takes effect at the following wrap.
- cycle_count wraps from 2^CW−1 to 0 silently.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. Reset, enable=1, PERIOD=10, run 30 cycles:
   - clk_out pattern 0×5, 1×5 repeating.
   - rise at cycles 5, 15, 25 after reset release; fall at cycles 10, 20, 30.
   - cycle_count reads 3 after cycle 25.
2. Deassert enable mid-high-phase (cycle 7) for 4 cycles:
   - clk_out stays 1 and rise/fall stay 0 while disabled.
   - Phase resumes where it stopped; next fall is delayed by exactly 4 cycles.
3. period_load with period_in=4 at cycle 3:
   - period_cur stays 10 until the wrap at cycle 10, then 4.
   - Waveform afterwards is 0,0,1,1 repeating, with no short phase.
4. period_in=7 and period_in=1:
   - 7 gives 4 low / 3 high.
   - 1 is clamped: period_cur=2, clk_out toggles every cycle.
5. reset asserted for one cycle mid-operation (cnt=8, pending load present):
   - Next cycle clk_out=0, cycle_count=0, period_cur=10, pending load discarded.
   - Reset wins even with enable=1 and period_load=1 on the same edge.
6. CW forced small (e.g. 4), run 16 rises:
   - cycle_count wraps 15→0 on the 16th rise.
